// File: rtl/uart_pkg.sv
// uart_pkg: shared states, error codes and defaults for the UART frame controller
package uart_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHECK, S_DRAIN} state_e;
  localparam logic [2:0] ERR_NONE = 3'd0;
  localparam logic [2:0] ERR_LEN  = 3'd1;
  localparam logic [2:0] ERR_CSUM = 3'd2;
  localparam logic [2:0] ERR_LINE = 3'd3;
  localparam logic [2:0] ERR_TMO  = 3'd4;
  localparam logic [2:0] ERR_OVR  = 3'd5;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
endpackage

// File: rtl/uart_frame_buf.sv
// uart_frame_buf: payload store, synchronous write and asynchronous read
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);
  logic [7:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: checks SYNC/LEN/payload/XOR frames and streams verified payloads
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT,
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT_CLKS = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_error,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last,
  output logic       frame_done,
  output logic       frame_err,
  output logic [2:0] err_code,
  output logic       busy
);
  localparam int PW = $clog2(MAX_LEN) + 1;
  localparam int AW = $clog2(MAX_LEN);
  localparam int TW = $clog2(TIMEOUT_CLKS) + 1;
  state_e        state_q;
  logic [PW-1:0] len_q, wr_q, rd_q;
  logic [7:0]    csum_q;
  logic [TW-1:0] tmo_q;
  logic          done_q, err_q;
  logic [2:0]    code_q;
  logic          active, tmo_hit, wr_en;
  logic [7:0]    rd_data;
  assign active  = state_q inside {S_LEN, S_PAYLOAD, S_CHECK};
  assign tmo_hit = tmo_q == TW'(TIMEOUT_CLKS - 1);
  assign wr_en   = state_q == S_PAYLOAD && rx_valid && !rx_error;
  assign m_valid    = state_q == S_DRAIN;
  assign m_data     = m_valid ? rd_data : 8'h00;
  assign m_last     = m_valid && rd_q == len_q - PW'(1);
  assign busy       = state_q != S_IDLE;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign err_code   = code_q;
  uart_frame_buf #(.DEPTH(MAX_LEN)) u_buf (
    .clk    (clk),
    .we_i   (wr_en),
    .waddr_i(wr_q[AW-1:0]),
    .wdata_i(rx_data),
    .raddr_i(rd_q[AW-1:0]),
    .rdata_o(rd_data)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      csum_q  <= '0;
      tmo_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      tmo_q  <= (rx_valid || !active) ? '0 : tmo_q + TW'(1);
      case (state_q)
        S_IDLE:
          if (rx_valid && rx_data == SYNC_BYTE) begin
            state_q <= S_LEN;
            csum_q  <= '0;
          end
        S_LEN, S_PAYLOAD, S_CHECK:
          if (rx_error) begin
            err_q   <= 1'b1;
            code_q  <= ERR_LINE;
            state_q <= S_IDLE;
          end else if (rx_valid) begin
            if (state_q == S_LEN) begin
              if (rx_data == 8'h00 || 32'(rx_data) > MAX_LEN) begin
                err_q   <= 1'b1;
                code_q  <= ERR_LEN;
                state_q <= S_IDLE;
              end else begin
                len_q   <= PW'(rx_data);
                csum_q  <= rx_data;
                wr_q    <= '0;
                state_q <= S_PAYLOAD;
              end
            end else if (state_q == S_PAYLOAD) begin
              csum_q <= csum_q ^ rx_data;
              wr_q   <= wr_q + PW'(1);
              if (wr_q == len_q - PW'(1)) state_q <= S_CHECK;
            end else if (rx_data == csum_q) begin
              done_q  <= 1'b1;
              rd_q    <= '0;
              state_q <= S_DRAIN;
            end else begin
              err_q   <= 1'b1;
              code_q  <= ERR_CSUM;
              state_q <= S_IDLE;
            end
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            code_q  <= ERR_TMO;
            state_q <= S_IDLE;
          end
        S_DRAIN: begin
          // incoming bytes are dropped, but the drain itself carries on
          if (rx_valid) begin
            err_q  <= 1'b1;
            code_q <= ERR_OVR;
          end
          if (m_ready) begin
            rd_q <= rd_q + PW'(1);
            if (rd_q == len_q - PW'(1)) begin
              rd_q    <= '0;
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule
